ysyx_25050147_mem_arbiter: RTL

Shares the single DPI-backed physical memory port between the instruction-fetch path (IFU) and the load/store path (LSU). It accepts one request at a time through a valid/ready handshake, arbitrates round-robin on ties, and inserts a programmable access latency. It drives a one-cycle memory strobe and returns read data with a single-cycle response pulse. It sits between the core front/back ends and the memory-access module.

---
 rtl/ysyx_25050147_mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ysyx_25050147_mem_arbiter.sv
// Shares one memory port between IFU and LSU: round-robin arbitration on ties,
// programmable pre-access latency, one-cycle strobe and one-cycle response pulse.
module ysyx_25050147_mem_arbiter #(
    parameter int unsigned LATENCY = 0,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_resp_valid,
    output logic [DW-1:0] ifu_rdata,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic          lsu_wen,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [7:0]    lsu_wmask,
    output logic          lsu_resp_valid,
    output logic [DW-1:0] lsu_rdata,
    output logic          mem_valid,
    output logic          mem_wen,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;

    localparam logic [3:0] WAIT_LOAD = (LATENCY != 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e        state_q, state_d;
    logic          last_lsu_q, last_lsu_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          own_lsu_q, own_lsu_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    wmask_q, wmask_d;
    logic [DW-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DW-1:0] lsu_rdata_q, lsu_rdata_d;

    logic grant_ifu, grant_lsu;

    // On a tie the side that did not win last time is served.
    assign grant_ifu = ifu_req_valid && (!lsu_req_valid || last_lsu_q);
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu_q);

    assign ifu_req_ready = (state_q == IDLE) && !rst && grant_ifu;
    assign lsu_req_ready = (state_q == IDLE) && !rst && grant_lsu;
    assign busy          = (state_q != IDLE);
    assign ifu_rdata     = ifu_rdata_q;
    assign lsu_rdata     = lsu_rdata_q;

    always_comb begin
        state_d        = state_q;
        last_lsu_d     = last_lsu_q;
        cnt_d          = cnt_q;
        own_lsu_d      = own_lsu_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        ifu_rdata_d    = ifu_rdata_q;
        lsu_rdata_d    = lsu_rdata_q;
        mem_valid      = 1'b0;
        mem_wen        = 1'b0;
        mem_raddr      = '0;
        mem_waddr      = '0;
        mem_wdata      = '0;
        mem_wmask      = '0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (ifu_req_ready || lsu_req_ready) begin
                    own_lsu_d  = lsu_req_ready;
                    last_lsu_d = lsu_req_ready;
                    addr_d     = lsu_req_ready ? lsu_addr : ifu_addr;
                    wen_d      = lsu_req_ready && lsu_wen;
                    wdata_d    = lsu_req_ready ? lsu_wdata : '0;
                    wmask_d    = lsu_req_ready ? lsu_wmask : '0;
                    cnt_d      = WAIT_LOAD;
                    state_d    = (LATENCY != 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ACCESS: begin
                mem_valid = 1'b1;
                mem_raddr = addr_q;
                if (wen_q) begin
                    mem_wen   = 1'b1;
                    mem_waddr = addr_q;
                    mem_wdata = wdata_q;
                    mem_wmask = wmask_q;
                end
                if (own_lsu_q) lsu_rdata_d = mem_rdata;
                else           ifu_rdata_d = mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                ifu_resp_valid = !own_lsu_q && !rst;
                lsu_resp_valid = own_lsu_q && !rst;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_lsu_q  <= 1'b1;
            cnt_q       <= '0;
            own_lsu_q   <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_lsu_q  <= last_lsu_d;
            cnt_q       <= cnt_d;
            own_lsu_q   <= own_lsu_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

endmodule
